// File: rtl/xil_prim_pkg.sv
// Shared helpers and legal-range constants for the primitive LUT models.
package xil_prim_pkg;

    localparam int unsigned K_MIN = 2;
    localparam int unsigned K_MAX = 8;

    // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cfglut_n.sv
// Runtime-reconfigurable K-input dual-output LUT. The truth table is a shift
// register loaded from INIT and rewritten serially, CFG_WIDTH bits per beat.
module cfglut_n
  import xil_prim_pkg::*;
#(
  parameter int unsigned       K         = 5,
  parameter int unsigned       CFG_WIDTH = 1,
  parameter logic [2**K-1:0]   INIT      = '0,
  parameter bit                OUT_REG   = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [K-1:0]         I,
  input  logic                 CE,
  input  logic [CFG_WIDTH-1:0] CDI,
  input  logic                 RELOAD,
  output logic [CFG_WIDTH-1:0] CDO,
  output logic                 O5,
  output logic                 O6,
  output logic                 CFG_DONE
);

  localparam int unsigned N     = 2**K;
  localparam int unsigned BEATS = N / CFG_WIDTH;
  localparam int unsigned CNT_W = clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (K < K_MIN || K > K_MAX) begin : g_bad_k
    $error("cfglut_n: K=%0d outside legal range %0d..%0d", K, K_MIN, K_MAX);
  end

  if (CFG_WIDTH == 0 || (CFG_WIDTH & (CFG_WIDTH - 1)) != 0 || CFG_WIDTH > N / 2) begin : g_bad_cw
    $error("cfglut_n: CFG_WIDTH=%0d must be a power of two no larger than %0d", CFG_WIDTH, N / 2);
  end

  logic [N-1:0]     lut_table;
  logic [CNT_W-1:0] beat_cnt;
  logic             o5_c;
  logic             o6_c;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lut_table <= INIT;
      beat_cnt  <= '0;
      CFG_DONE  <= 1'b0;
    end else if (RELOAD) begin
      lut_table <= INIT;
      beat_cnt  <= '0;
      CFG_DONE  <= 1'b0;
    end else if (CE) begin
      lut_table <= {lut_table[N-1-CFG_WIDTH:0], CDI};
      beat_cnt  <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
      CFG_DONE  <= (beat_cnt == LAST_BEAT);
    end else begin
      CFG_DONE  <= 1'b0;
    end
  end

  // O5 always reads the lower half of the table, ignoring I[K-1].
  always_comb begin
    o6_c = lut_table[I];
    o5_c = lut_table[{1'b0, I[K-2:0]}];
    CDO  = lut_table[N-1 -: CFG_WIDTH];
  end

  if (OUT_REG) begin : g_out_reg
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        O5 <= 1'b0;
        O6 <= 1'b0;
      end else begin
        O5 <= o5_c;
        O6 <= o6_c;
      end
    end
  end else begin : g_out_comb
    always_comb begin
      O5 = o5_c;
      O6 = o6_c;
    end
  end

endmodule
